logit_streamer: RTL and testbench
=================================

# logit_streamer

Transmit-side front end for the classifier output stage. Buffers one frame of `N_CLASSES` signed accumulator results written by the output-layer MAC array. On commit, it serialises them as a 32-bit signed element stream (element 0 first) with valid/ready/last. The stream feeds the argmax (hardmax) consumer, which takes one element per valid cycle.

## Interface
Parameters:
- `N_CLASSES`, 10: elements per frame (2..16).
- `ACC_W`, 40: accumulator input width (≥ 32).
- `DATA_W`, 32: output element width (fixed at 32; the consumer expects 32).

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `acc_we`  in  1  write strobe for one accumulator value.
- `acc_idx`  in  4  element index for the write.
- `acc_data`  in  ACC_W  signed accumulator value.
- `acc_commit`  in  1  frame complete; start streaming.
- `acc_ready`  out  1  buffer accepts writes/commit (FILL state).
- `z_tvalid`  out  1  output element valid.
- `z_tready`  in  1  consumer accepts the element; may be tied high.
- `z_tdata`  out  32  signed element value.
- `z_tlast`  out  1  high with element `N_CLASSES-1`.
- `z_tuser`  out  4  index of the current element.
- `wr_drop`  out  1  sticky; a write or commit arrived while not in FILL.

## Operation
- State machine with 2 states, FILL and STREAM. Reset state is FILL.
- Buffer: `N_CLASSES` x 32-bit registers, all cleared to 0 on reset. Contents persist between frames; entries not rewritten keep their old value.
- Behaviour in FILL:
  - `acc_ready` = 1.
  - `acc_we` with `acc_idx` < `N_CLASSES` writes the narrowed `acc_data` into `buf[acc_idx]`.
  - `acc_idx` ≥ `N_CLASSES` is ignored silently and does not set `wr_drop`.
  - Rewriting the same index: the last write wins.
- FILL -> STREAM on `acc_commit`. A write in the same cycle as commit is captured and included in the frame. Element counter `cnt` is set to 0.
- Commit with no writes is legal; it streams the current buffer contents.
- Behaviour in STREAM:
  - `z_tvalid` = 1, `z_tdata` = `buf[cnt]`, `z_tuser` = `cnt`, `z_tlast` = (`cnt` == `N_CLASSES-1`).
  - On a transfer (`z_tvalid` & `z_tready`), `cnt` increments.
  - On the transfer with `z_tlast` = 1: return to FILL and clear `cnt` to 0.
  - `acc_ready` = 0. Any `acc_we` or `acc_commit` is dropped, the buffer is unchanged, and `wr_drop` is set. `wr_drop` clears only on reset.
- Narrowing (applied at write time, `ACC_W` -> 32): see Configuration.

## Timing
- Reset values: `acc_ready`=1, `z_tvalid`=0, `z_tdata`=0, `z_tlast`=0, `z_tuser`=0, `wr_drop`=0, `cnt`=0.
- Reset mid-stream: the next cycle is FILL with the buffer zeroed. No partial frame resumes.
- Latency: commit sampled at edge t -> `z_tvalid`=1 with element 0 during cycle t+1.
- Throughput: with `z_tready` held high, one element per cycle. Frame = `N_CLASSES` cycles; `z_tlast` is high in cycle t+`N_CLASSES`.
- Backpressure: while `z_tvalid`=1 and `z_tready`=0, `z_tdata`, `z_tuser` and `z_tlast` hold stable. `z_tvalid` never drops before the transfer completes.
- After the last transfer at edge u: `z_tvalid`=0 and `acc_ready`=1 in cycle u+1. A commit at u+1 starts the next frame at u+2, giving a minimum 1-cycle gap between frames.
- `z_tready` is don't-care while `z_tvalid`=0.

## Configuration
- `LOGIT_STREAMER_SAT_EN` defined: signed saturation to 32 bits at write time.
  - Values > 2^31-1 store 0x7FFFFFFF.
  - Values < -2^31 store 0x80000000.
  - In-range values are stored unchanged.
- Not defined: truncation; `acc_data[31:0]` is stored. No saturation logic is generated.

## Test plan
- Basic frame, `z_tready`=1: write idx 0..9 with values 100,-5,7,300,0,-1,42,299,-300,1, then commit -> 10 consecutive valid cycles starting 1 cycle after commit. `z_tdata` in that order, `z_tuser` 0..9, `z_tlast` only on idx 9, then `acc_ready`=1.
- Backpressure: same frame, `z_tready` toggled 1,0,0,1,... -> every element transferred exactly once, in order. Data, user and last are stable during stalls; the frame ends after 10 transfers.
- Overflow with `LOGIT_STREAMER_SAT_EN`: write `acc_data`=0x01_0000_0005 at idx 2 and 0xFF_7FFF_FFFF at idx 3 -> stream shows 0x7FFFFFFF and 0x80000000. Without the macro -> 0x00000005 and 0x7FFFFFFF.
- Illegal access:
  - Write idx 12 in FILL -> ignored, `wr_drop`=0.
  - Write idx 4 during STREAM -> stream unchanged, `wr_drop`=1 and stays 1.
  - Next frame with no rewrite of idx 4 -> old idx 4 value is streamed.
- Simultaneous events:
  - Write idx 9 = 77 in the commit cycle -> element 9 = 77.
  - Commit in the cycle right after the last transfer -> next frame starts with a 1-cycle gap.
- Reset mid-stream: assert `rstn`=0 after element 4 transferred -> next cycle `z_tvalid`=0, `acc_ready`=1. A following empty commit streams ten zeros.

Source files
------------

// File: rtl/logit_streamer.sv
// logit_streamer: buffers one frame of N_CLASSES accumulator results and,
// on commit, streams them out as 32-bit signed elements with valid/ready/last.
// Optional feature macro: LOGIT_STREAMER_SAT_EN selects signed saturation
// of each accumulator value at write time (default build truncates).

module logit_streamer #(
   parameter int N_CLASSES = 10,
   parameter int ACC_W     = 40,
   parameter int DATA_W    = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              acc_we,
   input  logic [3:0]        acc_idx,
   input  logic [ACC_W-1:0]  acc_data,
   input  logic              acc_commit,
   output logic              acc_ready,
   output logic              z_tvalid,
   input  logic              z_tready,
   output logic [DATA_W-1:0] z_tdata,
   output logic              z_tlast,
   output logic [3:0]        z_tuser,
   output logic              wr_drop
);

   localparam logic S_FILL   = 1'b0;
   localparam logic S_STREAM = 1'b1;

   localparam logic [3:0] LAST_IDX = 4'(N_CLASSES - 1);

   logic              state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0] elem_q [N_CLASSES];
   logic [DATA_W-1:0] elem_d [N_CLASSES];
   logic [DATA_W-1:0] acc_narrow;
   logic [DATA_W-1:0] elem_sel;

`ifdef LOGIT_STREAMER_SAT_EN
   logic [ACC_W-32:0] acc_hi;

   // Clamp to the 32-bit signed range when the bits above bit 31 are not a pure sign extension
   always_comb begin
      acc_hi = acc_data[ACC_W-1:31];
      if (acc_hi == '0 || acc_hi == '1) begin
         acc_narrow = acc_data[31:0];
      end else if (acc_data[ACC_W-1]) begin
         acc_narrow = 32'h8000_0000;
      end else begin
         acc_narrow = 32'h7FFF_FFFF;
      end
   end
`else
   logic unused_acc_hi;

   // Plain truncation: only the low 32 bits of the accumulator are kept
   assign acc_narrow    = acc_data[31:0];
   assign unused_acc_hi = ^acc_data;
`endif

   // Select the buffer entry addressed by the element counter
   always_comb begin
      elem_sel = '0;
      for (int i = 0; i < N_CLASSES; i++) begin
         if (cnt_q == 4'(i)) begin
            elem_sel = elem_q[i];
         end
      end
   end

   assign acc_ready = (state_q == S_FILL);
   assign z_tvalid  = (state_q == S_STREAM);
   assign z_tdata   = z_tvalid ? elem_sel : '0;
   assign z_tuser   = cnt_q;
   assign z_tlast   = z_tvalid && (cnt_q == LAST_IDX);
   assign wr_drop   = wr_drop_q;

   // Next-state logic: buffer writes and commit in FILL, element sequencing in STREAM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_drop_d = wr_drop_q;
      for (int i = 0; i < N_CLASSES; i++) begin
         elem_d[i] = elem_q[i];
      end
      case (state_q)
         S_FILL: begin
            if (acc_we) begin
               for (int i = 0; i < N_CLASSES; i++) begin
                  if (acc_idx == 4'(i)) begin
                     elem_d[i] = acc_narrow;
                  end
               end
            end
            if (acc_commit) begin
               state_d = S_STREAM;
               cnt_d   = '0;
            end
         end
         S_STREAM: begin
            if (acc_we || acc_commit) begin
               wr_drop_d = 1'b1;
            end
            if (z_tready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = S_FILL;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_FILL;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset also zeroes the buffer
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= S_FILL;
         cnt_q     <= '0;
         wr_drop_q <= 1'b0;
         for (int i = 0; i < N_CLASSES; i++) begin
            elem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_drop_q <= wr_drop_d;
         for (int i = 0; i < N_CLASSES; i++) begin
            elem_q[i] <= elem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_logit_streamer.sv
// Directed testbench for logit_streamer. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.

module tb_logit_streamer;

   localparam int N = 10;

   logic        clk;
   logic        rstn;
   logic        acc_we;
   logic [3:0]  acc_idx;
   logic [39:0] acc_data;
   logic        acc_commit;
   logic        acc_ready;
   logic        z_tvalid;
   logic        z_tready;
   logic [31:0] z_tdata;
   logic        z_tlast;
   logic [3:0]  z_tuser;
   logic        wr_drop;

   int n_compared;
   int n_mismatched;

   logic [31:0] model [N];

   logit_streamer #(.N_CLASSES(N), .ACC_W(40), .DATA_W(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .acc_we     (acc_we),
      .acc_idx    (acc_idx),
      .acc_data   (acc_data),
      .acc_commit (acc_commit),
      .acc_ready  (acc_ready),
      .z_tvalid   (z_tvalid),
      .z_tready   (z_tready),
      .z_tdata    (z_tdata),
      .z_tlast    (z_tlast),
      .z_tuser    (z_tuser),
      .wr_drop    (wr_drop)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic write_elem(input logic [3:0] idx, input logic [39:0] data);
      acc_we   = 1'b1;
      acc_idx  = idx;
      acc_data = data;
      @(negedge clk);
      acc_we   = 1'b0;
   endtask

   task automatic commit_frame();
      acc_commit = 1'b1;
      @(negedge clk);
      acc_commit = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_compared += 6;
      if (acc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_acc_ready: got %b want 1", acc_ready); end
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tvalid: got %b want 0", z_tvalid); end
      if (z_tdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_tdata: got %h want 0", z_tdata); end
      if (z_tlast !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_tlast: got %b want 0", z_tlast); end
      if (z_tuser !== 4'd0) begin n_mismatched++; $display("[TB] FAIL reset_tuser: got %0d want 0", z_tuser); end
      if (wr_drop !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_wr_drop: got %b want 0", wr_drop); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_frame();
      int vals [N];
      vals = '{100, -5, 7, 300, 0, -1, 42, 299, -300, 1};
      z_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         model[i] = 32'(vals[i]);
         write_elem(4'(i), 40'(vals[i]));
      end
      commit_frame();
      for (int i = 0; i < N; i++) begin
         n_compared += 4;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL basic_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         if (z_tuser !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL basic_tuser[%0d]: got %0d want %0d", i, z_tuser, i); end
         if (z_tlast !== (i == N - 1)) begin n_mismatched++; $display("[TB] FAIL basic_tlast[%0d]: got %b want %b", i, z_tlast, (i == N - 1)); end
         @(negedge clk);
      end
      n_compared += 2;
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_end_tvalid: got %b want 0", z_tvalid); end
      if (acc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_end_acc_ready: got %b want 1", acc_ready); end
   endtask

   task automatic test_backpressure();
      logic [0:3] pat;
      int nxt;
      int k;
      pat = 4'b1001;
      nxt = 0;
      k   = 0;
      commit_frame();
      while (nxt < N && k < 100) begin
         z_tready = pat[k % 4];
         n_compared += 4;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_tvalid[%0d]: got %b want 1", nxt, z_tvalid); end
         if (z_tdata !== model[nxt]) begin n_mismatched++; $display("[TB] FAIL bp_tdata[%0d]: got %h want %h", nxt, z_tdata, model[nxt]); end
         if (z_tuser !== 4'(nxt)) begin n_mismatched++; $display("[TB] FAIL bp_tuser[%0d]: got %0d want %0d", nxt, z_tuser, nxt); end
         if (z_tlast !== (nxt == N - 1)) begin n_mismatched++; $display("[TB] FAIL bp_tlast[%0d]: got %b want %b", nxt, z_tlast, (nxt == N - 1)); end
         @(negedge clk);
         if (z_tready) nxt++;
         k++;
      end
      z_tready = 1'b1;
      n_compared += 2;
      if (nxt != N) begin n_mismatched++; $display("[TB] FAIL bp_transfers: got %0d want %0d", nxt, N); end
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_end_tvalid: got %b want 0", z_tvalid); end
   endtask

   task automatic test_overflow();
`ifdef LOGIT_STREAMER_SAT_EN
      model[2] = 32'h7FFF_FFFF;
      model[3] = 32'h8000_0000;
`else
      model[2] = 32'h0000_0005;
      model[3] = 32'h7FFF_FFFF;
`endif
      z_tready = 1'b1;
      write_elem(4'd2, 40'h01_0000_0005);
      write_elem(4'd3, 40'hFF_7FFF_FFFF);
      commit_frame();
      for (int i = 0; i < N; i++) begin
         n_compared += 2;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ovf_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL ovf_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal_access();
      z_tready = 1'b1;
      model[4] = 32'd1234;
      write_elem(4'd4, 40'd1234);
      write_elem(4'd12, 40'd999);
      n_compared++;
      if (wr_drop !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ill_fill_wr_drop: got %b want 0", wr_drop); end
      commit_frame();
      for (int i = 0; i < N; i++) begin
         if (i == 1) begin
            acc_we   = 1'b1;
            acc_idx  = 4'd4;
            acc_data = 40'd555;
         end
         if (i == 3) begin
            n_compared++;
            if (wr_drop !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_stream_wr_drop: got %b want 1", wr_drop); end
         end
         n_compared += 2;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL ill_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         @(negedge clk);
         acc_we = 1'b0;
      end
      n_compared += 2;
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ill_end_tvalid: got %b want 0", z_tvalid); end
      if (wr_drop !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ill_sticky_wr_drop: got %b want 1", wr_drop); end
      commit_frame();
      for (int i = 0; i < N; i++) begin
         n_compared += 2;
         if (z_tuser !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL ill_next_tuser[%0d]: got %0d want %0d", i, z_tuser, i); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL ill_next_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      z_tready   = 1'b1;
      acc_we     = 1'b1;
      acc_idx    = 4'd9;
      acc_data   = 40'd77;
      acc_commit = 1'b1;
      model[9]   = 32'd77;
      @(negedge clk);
      acc_we     = 1'b0;
      acc_commit = 1'b0;
      for (int i = 0; i < N; i++) begin
         n_compared += 3;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL b2b_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         if (z_tlast !== (i == N - 1)) begin n_mismatched++; $display("[TB] FAIL b2b_tlast[%0d]: got %b want %b", i, z_tlast, (i == N - 1)); end
         @(negedge clk);
      end
      n_compared += 2;
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_gap_tvalid: got %b want 0", z_tvalid); end
      if (acc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_gap_acc_ready: got %b want 1", acc_ready); end
      commit_frame();
      for (int i = 0; i < N; i++) begin
         n_compared += 3;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b2_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tuser !== 4'(i)) begin n_mismatched++; $display("[TB] FAIL b2b2_tuser[%0d]: got %0d want %0d", i, z_tuser, i); end
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL b2b2_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid_stream();
      z_tready = 1'b1;
      commit_frame();
      for (int i = 0; i < 5; i++) begin
         n_compared++;
         if (z_tdata !== model[i]) begin n_mismatched++; $display("[TB] FAIL rst_pre_tdata[%0d]: got %h want %h", i, z_tdata, model[i]); end
         @(negedge clk);
      end
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      n_compared += 4;
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_tvalid: got %b want 0", z_tvalid); end
      if (acc_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_mid_acc_ready: got %b want 1", acc_ready); end
      if (wr_drop !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_mid_wr_drop: got %b want 0", wr_drop); end
      if (z_tuser !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rst_mid_tuser: got %0d want 0", z_tuser); end
      commit_frame();
      for (int i = 0; i < N; i++) begin
         n_compared += 3;
         if (z_tvalid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_zero_tvalid[%0d]: got %b want 1", i, z_tvalid); end
         if (z_tdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_zero_tdata[%0d]: got %h want 0", i, z_tdata); end
         if (z_tlast !== (i == N - 1)) begin n_mismatched++; $display("[TB] FAIL rst_zero_tlast[%0d]: got %b want %b", i, z_tlast, (i == N - 1)); end
         @(negedge clk);
      end
      n_compared++;
      if (z_tvalid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_zero_end_tvalid: got %b want 0", z_tvalid); end
   endtask

   // Run every scenario in order, then report
   initial begin
      n_compared   = 0;
      n_mismatched = 0;
      rstn         = 1'b0;
      acc_we       = 1'b0;
      acc_idx      = 4'd0;
      acc_data     = 40'd0;
      acc_commit   = 1'b0;
      z_tready     = 1'b1;
      for (int i = 0; i < N; i++) model[i] = 32'h0;
      @(negedge clk);
      $display("[TB] starting logit_streamer tests");
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_overflow();
      test_illegal_access();
      test_back_to_back();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
